// File: rtl/lmsm_sequencer_pkg.sv
// Shared definitions for the LM/SM decode-stage micro-sequencer.
// Holds the opcodes, mask width, NOP encoding and the sequencer state type.
package lmsm_sequencer_pkg;

  localparam logic [3:0]  LM_OPCODE  = 4'b0110;
  localparam logic [3:0]  SM_OPCODE  = 4'b0111;
  localparam int          MASK_W     = 8;
  localparam logic [15:0] NOP_INSTR  = 16'hF000;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_t;

  // Drops the lowest set bit: the register just issued.
  function automatic logic [MASK_W-1:0] clear_lowest(input logic [MASK_W-1:0] m);
    return m & (m - MASK_W'(1));
  endfunction

endpackage

// File: rtl/lmsm_sequencer_lsb_find8.sv
// Lowest-set-bit priority encoder over an 8-bit register mask.
// Also reports whether any bit is set and whether exactly one bit is set.
module lsb_find8 (
  input  logic [7:0] vec_i,
  output logic [2:0] idx_o,
  output logic       any_o,
  output logic       onehot_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives idx_o and no latch is inferred.
    idx_o = '0;
    for (int i = 7; i >= 0; i--) begin
      if (vec_i[i]) idx_o = 3'(i);
    end
  end

  assign any_o    = |vec_i;
  assign onehot_o = any_o & ~|(vec_i & (vec_i - 8'd1));

endmodule

// File: rtl/lmsm_sequencer.sv
// Splits an LM/SM instruction into one micro-op per set mask bit, lowest register first,
// stalling fetch until the last micro-op has been issued.
module lmsm_sequencer
  import lmsm_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir_in,
  input  logic        ir_valid,
  input  logic        hold,
  input  logic        flush,
  output logic        modify_ir,
  output logic [2:0]  modify_pr2_ra,
  output logic        first_multiple,
  output logic        last_multiple,
  output logic        stall_fetch,
  output logic        busy
);

  state_t              state_q, state_d;
  logic [MASK_W-1:0]   rem_mask_q, rem_mask_d;
  logic [MASK_W-1:0]   src_mask;
  logic [2:0]          lsb_idx;
  logic                lsb_any, lsb_onehot;
  logic                is_mult, in_seq, issue;

  assign in_seq  = (state_q == SEQ);
  assign is_mult = ir_valid & ((ir_in[15:12] == LM_OPCODE) | (ir_in[15:12] == SM_OPCODE));

  // While sequencing, the frozen instruction is ignored and the remaining mask drives the encoder.
  assign src_mask = in_seq ? rem_mask_q : ir_in[MASK_W-1:0];

  lsb_find8 u_lsb_find (
    .vec_i    (src_mask),
    .idx_o    (lsb_idx),
    .any_o    (lsb_any),
    .onehot_o (lsb_onehot)
  );

  // A micro-op is presented this cycle; reset and flush suppress it combinationally.
  assign issue = reset & ~flush & (in_seq | (is_mult & lsb_any));

  assign modify_ir      = issue;
  assign modify_pr2_ra  = issue ? lsb_idx : 3'd0;
  assign first_multiple = issue & ~in_seq;
  assign last_multiple  = issue & lsb_onehot;
  assign stall_fetch    = reset & ~flush &
                          ((hold & (is_mult | in_seq)) | (issue & ~lsb_onehot));
  assign busy           = reset & in_seq;

  always_comb begin
    state_d    = state_q;
    rem_mask_d = rem_mask_q;
    if (flush) begin
      state_d    = IDLE;
      rem_mask_d = '0;
    end else if (!hold) begin
      if (issue && !lsb_onehot) begin
        state_d    = SEQ;
        rem_mask_d = clear_lowest(src_mask);
      end else if (in_seq) begin
        state_d    = IDLE;
        rem_mask_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rem_mask_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      rem_mask_q <= rem_mask_d;
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed-vector bench for lmsm_sequencer; each scenario task compares a packed
// view {modify_ir, ra[2:0], first, last, stall, busy} against hand-computed values.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ir_in;
  logic        ir_valid, hold, flush;
  logic        modify_ir, first_multiple, last_multiple, stall_fetch, busy;
  logic [2:0]  modify_pr2_ra;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] ir;
    logic        v, h, f;
    logic [7:0]  exp;
    logic [7:0]  msk;
  } vec_t;

  always #5 clk = ~clk;

  lmsm_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .ir_in          (ir_in),
    .ir_valid       (ir_valid),
    .hold           (hold),
    .flush          (flush),
    .modify_ir      (modify_ir),
    .modify_pr2_ra  (modify_pr2_ra),
    .first_multiple (first_multiple),
    .last_multiple  (last_multiple),
    .stall_fetch    (stall_fetch),
    .busy           (busy)
  );

  function automatic logic [7:0] obs();
    return {modify_ir, modify_pr2_ra, first_multiple, last_multiple, stall_fetch, busy};
  endfunction

  function automatic vec_t mk(input logic [15:0] ir, input logic v, input logic h,
                              input logic f, input logic [7:0] exp, input logic [7:0] msk);
    vec_t t;
    t.ir = ir; t.v = v; t.h = h; t.f = f; t.exp = exp; t.msk = msk;
    return t;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled 4 units later.
  task automatic drive(input logic [15:0] ir, input logic v, input logic h, input logic f);
    ir_in = ir; ir_valid = v; hold = h; flush = f;
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(16'h6025, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs() !== 8'h00) begin
      errors++;
      $display("FAIL reset_forced_outputs: got %b expected %b", obs(), 8'h00);
    end
    tick();
    reset = 1'b1;
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs() !== 8'h00) begin
      errors++;
      $display("FAIL reset_release_idle: got %b expected %b", obs(), 8'h00);
    end
    tick();
  endtask

  task automatic test_lm_basic();
    vec_t tv[$];
    tv.push_back(mk(16'h6025, 1, 0, 0, 8'b1_000_1_0_1_0, 8'hFF));
    tv.push_back(mk(16'h6025, 1, 0, 0, 8'b1_010_0_0_1_1, 8'hFF));
    tv.push_back(mk(16'h6025, 1, 0, 0, 8'b1_101_0_1_0_1, 8'hFF));
    tv.push_back(mk(16'h0000, 0, 0, 0, 8'b0_000_0_0_0_0, 8'hFF));
    foreach (tv[i]) begin
      drive(tv[i].ir, tv[i].v, tv[i].h, tv[i].f);
      checks++;
      if (obs() !== tv[i].exp) begin
        errors++;
        $display("FAIL lm_basic step %0d: got %b expected %b", i, obs(), tv[i].exp);
      end
      tick();
    end
  endtask

  task automatic test_single_and_empty();
    vec_t tv[$];
    tv.push_back(mk(16'h7080, 1, 0, 0, 8'b1_111_1_1_0_0, 8'hFF));
    tv.push_back(mk(16'h0000, 0, 0, 0, 8'b0_000_0_0_0_0, 8'hFF));
    tv.push_back(mk(16'h6000, 1, 0, 0, 8'b0_000_0_0_0_0, 8'hFF));
    tv.push_back(mk(16'h6000, 1, 0, 0, 8'b0_000_0_0_0_0, 8'hFF));
    tv.push_back(mk(16'h1003, 1, 0, 0, 8'b0_000_0_0_0_0, 8'hFF));
    tv.push_back(mk(16'h7080, 1, 1, 0, 8'b1_111_1_1_1_0, 8'hFF));
    tv.push_back(mk(16'h7080, 1, 0, 0, 8'b1_111_1_1_0_0, 8'hFF));
    tv.push_back(mk(16'h0000, 0, 0, 0, 8'b0_000_0_0_0_0, 8'hFF));
    foreach (tv[i]) begin
      drive(tv[i].ir, tv[i].v, tv[i].h, tv[i].f);
      checks++;
      if (obs() !== tv[i].exp) begin
        errors++;
        $display("FAIL single_empty step %0d: got %b expected %b", i, obs(), tv[i].exp);
      end
      tick();
    end
  endtask

  task automatic test_hold();
    vec_t tv[$];
    tv.push_back(mk(16'h700F, 1, 0, 0, 8'b1_000_1_0_1_0, 8'hFF));
    tv.push_back(mk(16'h700F, 1, 1, 0, 8'b1_001_0_0_1_1, 8'hFF));
    tv.push_back(mk(16'h700F, 1, 1, 0, 8'b1_001_0_0_1_1, 8'hFF));
    tv.push_back(mk(16'h700F, 1, 0, 0, 8'b1_001_0_0_1_1, 8'hFF));
    tv.push_back(mk(16'h700F, 1, 0, 0, 8'b1_010_0_0_1_1, 8'hFF));
    tv.push_back(mk(16'h700F, 1, 0, 0, 8'b1_011_0_1_0_1, 8'hFF));
    tv.push_back(mk(16'h0000, 0, 0, 0, 8'b0_000_0_0_0_0, 8'hFF));
    foreach (tv[i]) begin
      drive(tv[i].ir, tv[i].v, tv[i].h, tv[i].f);
      checks++;
      if (obs() !== tv[i].exp) begin
        errors++;
        $display("FAIL hold step %0d: got %b expected %b", i, obs(), tv[i].exp);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    vec_t tv[$];
    // Register index is not compared while flushing.
    tv.push_back(mk(16'h60FF, 1, 0, 0, 8'b1_000_1_0_1_0, 8'hFF));
    tv.push_back(mk(16'h60FF, 1, 0, 0, 8'b1_001_0_0_1_1, 8'hFF));
    tv.push_back(mk(16'h60FF, 1, 0, 0, 8'b1_010_0_0_1_1, 8'hFF));
    tv.push_back(mk(16'h60FF, 1, 0, 0, 8'b1_011_0_0_1_1, 8'hFF));
    tv.push_back(mk(16'h60FF, 1, 0, 1, 8'b0_000_0_0_0_1, 8'h8F));
    tv.push_back(mk(16'h0000, 0, 0, 0, 8'b0_000_0_0_0_0, 8'hFF));
    tv.push_back(mk(16'h6003, 1, 0, 1, 8'b0_000_0_0_0_0, 8'h8F));
    tv.push_back(mk(16'h0000, 0, 0, 0, 8'b0_000_0_0_0_0, 8'hFF));
    tv.push_back(mk(16'h6003, 1, 0, 0, 8'b1_000_1_0_1_0, 8'hFF));
    tv.push_back(mk(16'h6003, 1, 0, 0, 8'b1_001_0_1_0_1, 8'hFF));
    tv.push_back(mk(16'h0000, 0, 0, 0, 8'b0_000_0_0_0_0, 8'hFF));
    foreach (tv[i]) begin
      drive(tv[i].ir, tv[i].v, tv[i].h, tv[i].f);
      checks++;
      if ((obs() & tv[i].msk) !== tv[i].exp) begin
        errors++;
        $display("FAIL flush step %0d: got %b expected %b (mask %b)",
                 i, obs(), tv[i].exp, tv[i].msk);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    vec_t tv[$];
    tv.push_back(mk(16'h6003, 1, 0, 0, 8'b1_000_1_0_1_0, 8'hFF));
    tv.push_back(mk(16'h6003, 1, 0, 0, 8'b1_001_0_1_0_1, 8'hFF));
    tv.push_back(mk(16'h7006, 1, 0, 0, 8'b1_001_1_0_1_0, 8'hFF));
    tv.push_back(mk(16'h7006, 1, 0, 0, 8'b1_010_0_1_0_1, 8'hFF));
    tv.push_back(mk(16'h0000, 0, 0, 0, 8'b0_000_0_0_0_0, 8'hFF));
    foreach (tv[i]) begin
      drive(tv[i].ir, tv[i].v, tv[i].h, tv[i].f);
      checks++;
      if (obs() !== tv[i].exp) begin
        errors++;
        $display("FAIL back_to_back step %0d: got %b expected %b", i, obs(), tv[i].exp);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_sequence();
    drive(16'h70F0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs() !== 8'b1_100_1_0_1_0) begin
      errors++;
      $display("FAIL midreset_first: got %b expected %b", obs(), 8'b1_100_1_0_1_0);
    end
    tick();
    drive(16'h70F0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs() !== 8'b1_101_0_0_1_1) begin
      errors++;
      $display("FAIL midreset_second: got %b expected %b", obs(), 8'b1_101_0_0_1_1);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs() !== 8'h00) begin
      errors++;
      $display("FAIL midreset_async_clear: got %b expected %b", obs(), 8'h00);
    end
    tick();
    reset = 1'b1;
    drive(16'h70F0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs() !== 8'h00) begin
      errors++;
      $display("FAIL midreset_release: got %b expected %b", obs(), 8'h00);
    end
    tick();
    drive(16'h70F0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs() !== 8'h00) begin
      errors++;
      $display("FAIL midreset_no_resume: got %b expected %b", obs(), 8'h00);
    end
    tick();
  endtask

  initial begin
    ir_in = '0; ir_valid = 1'b0; hold = 1'b0; flush = 1'b0; reset = 1'b0;
    test_reset();
    test_lm_basic();
    test_single_and_empty();
    test_hold();
    test_flush();
    test_back_to_back();
    test_reset_mid_sequence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
